step_freq_decoder: RTL and testbench
====================================

# step_freq_decoder

Converts the 32-bit DDS frequency control word into the output frequency it selects, in binary Hz and 8-digit packed BCD, for the seven-segment frequency display. It sits between the step-word generator (button-driven, not clocked in the system domain) and the display driver. It re-synchronises the word, detects changes, and runs a sequential shift-add multiply followed by a double-dabble conversion. It raises a one-cycle valid pulse per new result.

## Interface
- CLK_HZ, 50_000_000, DDS accumulator clock in Hz; legal range 1..67_108_863, so the Hz result fits in 26 bits.
- clk  input  1  system clock; all logic rising-edge.
- reset  input  1  reset, asynchronous, active-low.
- step  input  32  frequency control word; asynchronous to clk, may change at any time.
- hz  output  26  frequency in Hz, rounded to nearest.
- bcd  output  32  hz as 8 packed BCD digits, digit 7 in [31:28].
- valid  output  1  one-cycle pulse when hz/bcd update.
- busy  output  1  high while a conversion is in progress.

## Operation
- Input capture: step feeds a two-stage register chain s1 then s2.
  - A word is accepted only in IDLE, when s1 == s2 (stable for one cycle) and s2 != last.
  - last holds the most recently accepted word.
  - On acceptance, s2 is copied to op and last, and the block enters MUL.
- FSM states: IDLE, MUL, ROUND, BCD, DONE.
  - IDLE -> MUL on acceptance.
  - MUL -> ROUND after 32 iterations.
  - ROUND -> BCD.
  - BCD -> DONE after 26 iterations.
  - DONE -> IDLE unconditionally.
- MUL: 58-bit accumulator acc, cleared on entry. On iteration i (0..31), if op[i] == 1, acc += CLK_HZ << i. A 5-bit counter tracks i.
- ROUND: hz_r = (acc + 2^31) >> 32, a 26-bit result that rounds half up.
- BCD: double-dabble over 26 iterations, one per cycle.
  - Each cycle, add 3 to every BCD digit >= 5, then shift the {bcd_r, hz shift copy} pair left by one.
  - A 5-bit counter tracks the iteration.
- DONE: register hz <= hz_r and bcd <= bcd_r, and assert valid for this single cycle.
- Changes to step while busy are ignored. They are re-evaluated on return to IDLE, so the final settled word is always converted.
- The multiply is exact: no overflow is possible, because acc < 2^58.

## Timing
- Reset values: s1 = 0, s2 = 0, last = 0, op = 0, acc = 0, hz = 0, bcd = 0x00000000, valid = 0, busy = 0, state IDLE.
- hz = 0 / bcd = 0 is the correct result for step 0, so no conversion runs after reset while step stays 0.
- Input-change to acceptance: a step change settles through s1/s2. Acceptance occurs at earliest on the 3rd rising edge after the change, if the block is IDLE.
- Let acceptance occur at edge C:
  - MUL occupies cycles C+1..C+32.
  - ROUND occupies C+33.
  - BCD occupies C+34..C+59.
  - DONE occupies C+60. hz, bcd and valid are visible after edge C+60; valid drops after C+61.
  - Fixed latency is 60 cycles from acceptance to result.
- busy is high from after edge C through the DONE cycle, and low again after the DONE -> IDLE edge.
- Earliest next acceptance is 1 cycle after the return to IDLE.
- hz and bcd hold their previous values throughout a conversion and never show partial results.
- Reset asserted mid-conversion: all state returns to reset values immediately. No valid pulse is produced for the aborted word.
- After reset release, a nonzero step is picked up within 3 cycles.
- Back-to-back identical words produce no conversion and no valid pulse.

## Test plan
- Reset with step = 171798691 held, then release -> exactly one valid pulse, 63 cycles after reset release at most; hz = 2000000, bcd = 0x02000000, busy low afterwards.
- step = 85899, then 858993, spaced 200 cycles apart -> hz = 1000 / bcd = 0x00001000, then hz = 10000 / bcd = 0x00010000; each valid exactly 60 cycles after acceptance.
- Boundary words: step = 0xFFFFFFFF -> hz = 50000000, bcd = 0x50000000. step = 85 -> hz = 1, bcd = 0x00000001. step = 0 from a nonzero state -> hz = 0, bcd = 0.
- step changed 3 times during one conversion, final value 171798691 -> the first result is delivered unchanged. It is followed by exactly one further conversion of 171798691, with no conversions of the intermediate words.
- Reset pulsed low at cycle C+20 of a conversion -> hz = 0, bcd = 0, busy = 0 at once, and no valid pulse for the aborted word. The conversion then restarts from the current step after release.
- Same word rewritten repeatedly (step glitch-free, unchanged) -> no valid pulse and busy stays 0.

Source files
------------

// File: rtl/step_freq_decoder.sv
// rtl/step_freq_decoder.sv - DDS step word to Hz and packed BCD converter for the frequency display
module step_freq_decoder #(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] step,
  output logic [25:0] hz,
  output logic [31:0] bcd,
  output logic        valid,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    ROUND,
    BCD,
    DONE
  } state_t;

  localparam logic [57:0] CLK_W = 58'(CLK_HZ);
  localparam logic [57:0] HALF  = 58'd1 << 31;

  state_t      state;
  state_t      state_nx;

  logic [31:0] s1;
  logic [31:0] s2;
  logic [31:0] last;
  logic [31:0] op;
  logic [57:0] acc;
  logic [4:0]  cnt;
  logic [25:0] hz_r;
  logic [25:0] hz_sh;
  logic [31:0] bcd_r;

  logic        accept;
  logic [57:0] addend;
  logic [25:0] rnd;
  logic [31:0] bcd_adj;

  // A word is taken only when idle, stable across s1/s2 and different from the last one converted
  assign accept = (state == IDLE) && (s1 == s2) && (s2 != last);
  assign busy   = (state != IDLE);

  // Partial product for the current multiplier bit and the rounded integer Hz value
  always_comb begin
    addend = CLK_W << cnt;
    rnd    = 26'((acc + HALF) >> 32);
  end

  // Double-dabble correction: every BCD digit of 5 or more gets 3 added before the shift
  always_comb begin
    bcd_adj = bcd_r;
    for (int d = 0; d < 8; d++) begin
      if (bcd_r[4*d +: 4] >= 4'd5) begin
        bcd_adj[4*d +: 4] = bcd_r[4*d +: 4] + 4'd3;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic; cnt counts 0..31 in MUL and 0..25 in BCD
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = MUL;
      MUL:     if (cnt == 5'd31) state_nx = ROUND;
      ROUND:   state_nx = BCD;
      BCD:     if (cnt == 5'd25) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Input synchroniser, shift-add multiply, rounding, double-dabble and result registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1    <= '0;
      s2    <= '0;
      last  <= '0;
      op    <= '0;
      acc   <= '0;
      cnt   <= '0;
      hz_r  <= '0;
      hz_sh <= '0;
      bcd_r <= '0;
      hz    <= '0;
      bcd   <= '0;
      valid <= 1'b0;
    end else begin
      s1    <= step;
      s2    <= s1;
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            op   <= s2;
            last <= s2;
            acc  <= '0;
            cnt  <= '0;
          end
        end
        MUL: begin
          if (op[cnt]) begin
            acc <= acc + addend;
          end
          // wraps from 31 back to 0, ready for the BCD pass
          cnt <= cnt + 5'd1;
        end
        ROUND: begin
          hz_r  <= rnd;
          hz_sh <= rnd;
          bcd_r <= '0;
          cnt   <= '0;
        end
        BCD: begin
          {bcd_r, hz_sh} <= {bcd_adj, hz_sh} << 1;
          cnt            <= cnt + 5'd1;
        end
        DONE: begin
          hz    <= hz_r;
          bcd   <= bcd_r;
          valid <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_step_freq_decoder.sv
// tb/tb_step_freq_decoder.sv - self-checking bench for step_freq_decoder
module tb_step_freq_decoder;

  localparam int unsigned CLK_HZ = 50_000_000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] step = 32'd0;
  logic [25:0] hz;
  logic [31:0] bcd;
  logic        valid;
  logic        busy;

  int          cyc = 0;
  int          valid_count = 0;
  int          n_asserts = 0;
  int          n_fail = 0;
  logic [25:0] prev_hz = '0;

  step_freq_decoder #(.CLK_HZ(CLK_HZ)) dut (
    .clk   (clk),
    .reset (reset),
    .step  (step),
    .hz    (hz),
    .bcd   (bcd),
    .valid (valid),
    .busy  (busy)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (valid) valid_count <= valid_count + 1;

  function automatic logic [25:0] model_hz(input logic [31:0] w);
    longint unsigned p;
    p = 64'(w) * 64'(CLK_HZ) + 64'h8000_0000;
    return 26'(p >> 32);
  endfunction

  function automatic logic [31:0] model_bcd(input logic [25:0] h);
    int unsigned v;
    logic [31:0] r;
    v = 32'(h);
    r = '0;
    for (int d = 0; d < 8; d++) begin
      r[4*d +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input int budget, input string tag, output bit ok);
    int vc0;
    vc0 = valid_count;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (valid_count != vc0) begin
        ok = 1'b1;
        break;
      end
    end
    check({tag, "_valid_seen"}, 64'(ok), 64'd1);
  endtask

  task automatic run_word(input logic [31:0] w, input string tag);
    int          start;
    int          vc0;
    bit          ok;
    logic [25:0] eh;
    eh = model_hz(w);
    tick();
    step  = w;
    start = cyc;
    vc0   = valid_count;
    repeat (30) tick();
    check({tag, "_busy_mid"}, 64'(busy), 64'd1);
    check({tag, "_hz_hold"}, 64'(hz), 64'(prev_hz));
    wait_valid(50, tag, ok);
    if (ok) begin
      check({tag, "_latency"}, 64'(cyc - start), 64'd63);
      check({tag, "_hz"}, 64'(hz), 64'(eh));
      check({tag, "_bcd"}, 64'(bcd), 64'(model_bcd(eh)));
      check({tag, "_busy_done"}, 64'(busy), 64'd0);
      tick();
      check({tag, "_valid_drop"}, 64'(valid), 64'd0);
    end
    repeat (5) tick();
    check({tag, "_one_pulse"}, 64'(valid_count), 64'(vc0 + 1));
    prev_hz = eh;
  endtask

  initial begin
    int          r;
    int          s;
    int          vc0;
    bit          ok;
    bit          busy_seen;
    logic [31:0] w;

    // reset state with a nonzero word already present
    step = 32'd171798691;
    repeat (4) tick();
    check("rst_hz", 64'(hz), 64'd0);
    check("rst_bcd", 64'(bcd), 64'd0);
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);

    // release: word picked up and converted once
    reset = 1'b1;
    r = cyc;
    wait_valid(80, "rst_conv", ok);
    if (ok) begin
      check("rst_conv_latency_le63", 64'((cyc - r) <= 63), 64'd1);
      check("rst_conv_hz", 64'(hz), 64'd2000000);
      check("rst_conv_bcd", 64'(bcd), 64'h02000000);
    end
    repeat (100) tick();
    check("rst_conv_count", 64'(valid_count), 64'd1);
    check("rst_conv_busy_after", 64'(busy), 64'd0);
    prev_hz = 26'd2000000;

    // spaced words, 200 cycles apart
    run_word(32'd85899, "w1k");
    repeat (130) tick();
    run_word(32'd858993, "w10k");
    check("w10k_bcd_const", 64'(bcd), 64'h00010000);
    repeat (20) tick();

    // boundaries
    run_word(32'hFFFF_FFFF, "wmax");
    check("wmax_bcd_const", 64'(bcd), 64'h50000000);
    run_word(32'd85, "w85");
    check("w85_hz_const", 64'(hz), 64'd1);
    run_word(32'd0, "wzero");
    check("wzero_bcd_const", 64'(bcd), 64'd0);

    // random words against the arithmetic model
    for (int i = 0; i < 6; i++) begin
      w = $urandom;
      run_word(w, $sformatf("rnd%0d", i));
    end

    // word changes while busy: first result intact, then only the final word
    tick();
    step = 32'd12345678;
    s    = cyc;
    vc0  = valid_count;
    repeat (10) tick();
    step = 32'd111;
    repeat (10) tick();
    step = 32'd222222;
    repeat (10) tick();
    step = 32'd171798691;
    wait_valid(60, "chg_first", ok);
    if (ok) begin
      check("chg_first_latency", 64'(cyc - s), 64'd63);
      check("chg_first_hz", 64'(hz), 64'(model_hz(32'd12345678)));
    end
    wait_valid(80, "chg_second", ok);
    if (ok) begin
      check("chg_second_latency", 64'(cyc - s), 64'd124);
      check("chg_second_hz", 64'(hz), 64'd2000000);
      check("chg_second_bcd", 64'(bcd), 64'h02000000);
    end
    repeat (150) tick();
    check("chg_pulse_count", 64'(valid_count), 64'(vc0 + 2));

    // reset in the middle of a conversion
    tick();
    step = 32'd85899;
    s    = cyc;
    vc0  = valid_count;
    repeat (23) tick();
    reset = 1'b0;
    #1;
    check("abort_hz", 64'(hz), 64'd0);
    check("abort_bcd", 64'(bcd), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_valid", 64'(valid), 64'd0);
    repeat (2) tick();
    check("abort_no_pulse", 64'(valid_count), 64'(vc0));
    reset = 1'b1;
    r = cyc;
    wait_valid(80, "abort_restart", ok);
    if (ok) begin
      check("abort_restart_latency_le63", 64'((cyc - r) <= 63), 64'd1);
      check("abort_restart_hz", 64'(hz), 64'd1000);
      check("abort_restart_bcd", 64'(bcd), 64'h00001000);
      check("abort_restart_count", 64'(valid_count), 64'(vc0 + 1));
    end
    repeat (5) tick();

    // same word rewritten: nothing happens
    vc0       = valid_count;
    busy_seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      step = 32'd85899;
      if (busy) busy_seen = 1'b1;
    end
    check("same_no_pulse", 64'(valid_count), 64'(vc0));
    check("same_no_busy", 64'(busy_seen), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
